// File: rtl/switch_toggle_bank.sv
// Multi-channel switch front end: synchronise, debounce, edge-detect, then drive
// a toggle/follow LED and a wrapping event counter per channel.
module switch_toggle_bank #(
   parameter int unsigned         CHANNELS        = 4,
   parameter int unsigned         DEBOUNCE_CYCLES = 250000,
   parameter int unsigned         EDGE            = 0,
   parameter int unsigned         COUNT_WIDTH     = 4,
   parameter logic [CHANNELS-1:0] LED_INIT        = '0
) (
   input  logic                            i_clk,
   input  logic                            i_rst,
   input  logic [CHANNELS-1:0]             i_switch,
   input  logic [1:0]                      i_mode,
   input  logic                            i_clear,
   output logic [CHANNELS-1:0]             o_led,
   output logic [CHANNELS-1:0]             o_event,
   output logic [CHANNELS*COUNT_WIDTH-1:0] o_count
);

   localparam int unsigned    DBW     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);

   // Reserved mode encodings fall through to toggle behaviour.
   logic follow_c;
   assign follow_c = (i_mode == 2'b01);

   for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
      logic                   sync1;
      logic                   s;
      logic                   d;
      logic                   d_q;
      logic [DBW-1:0]         c;
      logic                   evt_c;
      logic                   led_q;
      logic                   evt_q;
      logic [COUNT_WIDTH-1:0] cnt_q;

      always_ff @(posedge i_clk or posedge i_rst) begin
         if (i_rst) begin
            sync1 <= 1'b0;
            s     <= 1'b0;
         end else begin
            sync1 <= i_switch[n];
            s     <= sync1;
         end
      end

      // Any cycle where s agrees with d restarts the debounce window.
      always_ff @(posedge i_clk or posedge i_rst) begin
         if (i_rst) begin
            d   <= 1'b0;
            d_q <= 1'b0;
            c   <= '0;
         end else begin
            d_q <= d;
            if (s == d) begin
               c <= '0;
            end else if (c == DB_LAST) begin
               d <= s;
               c <= '0;
            end else begin
               c <= c + DBW'(1);
            end
         end
      end

      assign evt_c = (EDGE != 0) ? (~d_q & d) : (d_q & ~d);

      // Clear wins over an event for LED and counter, but the event pulse still goes out.
      always_ff @(posedge i_clk or posedge i_rst) begin
         if (i_rst) begin
            led_q <= LED_INIT[n];
            evt_q <= 1'b0;
            cnt_q <= '0;
         end else begin
            evt_q <= evt_c;
            if (i_clear) begin
               led_q <= LED_INIT[n];
               cnt_q <= '0;
            end else begin
               if (follow_c) begin
                  led_q <= d;
               end else if (evt_c) begin
                  led_q <= ~led_q;
               end
               if (evt_c) begin
                  cnt_q <= cnt_q + COUNT_WIDTH'(1);
               end
            end
         end
      end

      assign o_led[n]                             = led_q;
      assign o_event[n]                           = evt_q;
      assign o_count[n*COUNT_WIDTH +: COUNT_WIDTH] = cnt_q;
   end

endmodule

// File: tb/tb_switch_toggle_bank.sv
// Directed bench for switch_toggle_bank: instance a (release edge, 4-bit counters,
// LED_INIT=2'b10) and instance b (press edge, 2-bit counters).
module tb_switch_toggle_bank;

   logic       clk;
   logic       rst_a, rst_b;
   logic [1:0] sw_a, sw_b;
   logic [1:0] mode_a, mode_b;
   logic       clr_a, clr_b;
   logic [1:0] led_a, led_b;
   logic [1:0] evt_a, evt_b;
   logic [7:0] cnt_a;
   logic [3:0] cnt_b;

   int         n_cmp = 0;
   int         n_err = 0;
   logic [1:0] seen;
   logic [1:0] tmp;
   int         exp_b [5] = '{1, 2, 3, 0, 1};

   switch_toggle_bank #(
      .CHANNELS(2), .DEBOUNCE_CYCLES(4), .EDGE(0), .COUNT_WIDTH(4), .LED_INIT(2'b10)
   ) u_dut_a (
      .i_clk(clk), .i_rst(rst_a), .i_switch(sw_a), .i_mode(mode_a), .i_clear(clr_a),
      .o_led(led_a), .o_event(evt_a), .o_count(cnt_a)
   );

   switch_toggle_bank #(
      .CHANNELS(2), .DEBOUNCE_CYCLES(4), .EDGE(1), .COUNT_WIDTH(2), .LED_INIT(2'b00)
   ) u_dut_b (
      .i_clk(clk), .i_rst(rst_b), .i_switch(sw_b), .i_mode(mode_b), .i_clear(clr_b),
      .o_led(led_b), .o_event(evt_b), .o_count(cnt_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic watch_a(input int n, output logic [1:0] acc);
      acc = '0;
      repeat (n) begin
         tick(1);
         acc |= evt_a;
      end
   endtask

   initial begin
      rst_a = 1'b1; rst_b = 1'b1;
      sw_a = '0; sw_b = '0; mode_a = '0; mode_b = '0; clr_a = 1'b0; clr_b = 1'b0;
      tick(3);
      check("a_rst_led", 32'(led_a), 2);
      check("a_rst_evt", 32'(evt_a), 0);
      check("a_rst_cnt", 32'(cnt_a), 0);
      rst_a = 1'b0; rst_b = 1'b0;
      tick(2);

      // release edge on ch0, press ignored
      sw_a = 2'b01;
      watch_a(12, seen);
      check("a_press_noevt", 32'(seen), 0);
      sw_a = 2'b00;
      watch_a(6, seen);
      check("a_rel_early", 32'(seen), 0);
      tick(1);
      check("a_rel_evt", 32'(evt_a), 1);
      check("a_rel_led", 32'(led_a), 3);
      check("a_rel_cnt", 32'(cnt_a), 8'h01);
      tick(1);
      check("a_evt_single", 32'(evt_a), 0);
      tick(5);

      // bounce every 2 cycles, settle high, then clean release
      seen = '0;
      for (int i = 0; i < 10; i++) begin
         sw_a[0] = (i % 2 == 0);
         watch_a(2, tmp);
         seen |= tmp;
      end
      sw_a = 2'b01;
      watch_a(12, tmp);
      seen |= tmp;
      check("a_bounce_noevt", 32'(seen), 0);
      check("a_bounce_led", 32'(led_a), 3);
      sw_a = 2'b00;
      watch_a(12, seen);
      check("a_settle_evt", 32'(seen), 1);
      check("a_settle_led", 32'(led_a), 2);
      check("a_settle_cnt", 32'(cnt_a), 8'h02);

      // clear coincident with an event
      sw_a = 2'b01;
      tick(12);
      sw_a = 2'b00;
      tick(6);
      clr_a = 1'b1;
      tick(1);
      check("a_clr_evt", 32'(evt_a), 1);
      check("a_clr_led", 32'(led_a), 2);
      check("a_clr_cnt", 32'(cnt_a), 0);
      clr_a = 1'b0;
      tick(5);
      sw_a = 2'b01;
      tick(12);
      sw_a = 2'b00;
      tick(12);
      check("a_post_clr_led", 32'(led_a), 3);
      check("a_post_clr_cnt", 32'(cnt_a), 8'h01);

      // follow mode, then switch to toggle mid-hold
      mode_a = 2'b01;
      tick(1);
      check("a_fol_init", 32'(led_a), 0);
      sw_a = 2'b01;
      tick(6);
      check("a_fol_press_early", 32'(led_a), 0);
      tick(1);
      check("a_fol_press", 32'(led_a), 1);
      tick(5);
      sw_a = 2'b00;
      tick(6);
      check("a_fol_rel_early", 32'(led_a), 1);
      tick(1);
      check("a_fol_rel_led", 32'(led_a), 0);
      check("a_fol_rel_evt", 32'(evt_a), 1);
      check("a_fol_rel_cnt", 32'(cnt_a), 8'h02);
      tick(5);
      sw_a = 2'b01;
      tick(12);
      check("a_fol_hold", 32'(led_a), 1);
      mode_a = 2'b00;
      tick(3);
      check("a_tog_keep", 32'(led_a), 1);
      sw_a = 2'b00;
      tick(7);
      check("a_tog_evt", 32'(evt_a), 1);
      check("a_tog_led", 32'(led_a), 0);
      check("a_tog_cnt", 32'(cnt_a), 8'h03);
      tick(5);

      // press edge, 2-bit counter wrap on ch1
      for (int i = 0; i < 5; i++) begin
         sw_b = 2'b10;
         tick(6);
         check("b_press_early", 32'(evt_b), 0);
         tick(1);
         check("b_press_evt", 32'(evt_b), 2);
         check("b_press_cnt", 32'(cnt_b[3:2]), 32'(exp_b[i]));
         tick(5);
         sw_b = 2'b00;
         seen = '0;
         repeat (12) begin
            tick(1);
            seen |= evt_b;
         end
         check("b_rel_noevt", 32'(seen), 0);
      end
      check("b_led", 32'(led_b), 2);

      // asynchronous reset mid-debounce with the switch held
      sw_b = 2'b01;
      tick(4);
      #2;
      rst_b = 1'b1;
      #1;
      check("b_arst_led", 32'(led_b), 0);
      check("b_arst_evt", 32'(evt_b), 0);
      check("b_arst_cnt", 32'(cnt_b), 0);
      tick(2);
      rst_b = 1'b0;
      seen = '0;
      repeat (6) begin
         tick(1);
         seen |= evt_b;
      end
      check("b_post_rst_early", 32'(seen), 0);
      tick(1);
      check("b_post_rst_evt", 32'(evt_b), 1);
      check("b_post_rst_led", 32'(led_b), 1);
      check("b_post_rst_cnt", 32'(cnt_b), 4'b0001);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
